dtw_sdtw_array: RTL and testbench
=================================

# dtw_sdtw_array

Parametrised linear systolic array of NPE dynamic-time-warping processing elements. It computes the full DTW cost matrix of a stored reference (NPE samples) against a streamed query, one query sample per cycle. It supports global (full) and subsequence (free-start/free-end) alignment, saturating cost accumulation, per-column score output and best-score tracking. It is the multi-PE successor to the single-cell DTW PE and sits between the sample normaliser and the match-decision logic.

## Interface
- WIDTH, 16: signed sample width.
- CWIDTH, 24: unsigned accumulated-cost width; the all-ones value is INF and is also the saturation ceiling.
- NPE, 8: PEs, i.e. the reference length (≥2).
- QW, 16: query length/position width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- mode  in  1  sampled at start; 0 = full DTW, 1 = subsequence DTW.
- qlen  in  QW  query length, sampled at start; 0 is treated as 1.
- ref_valid / ref_ready  in/out  1  reference-load handshake.
- ref_data  in  WIDTH  reference sample.
- s_valid / s_ready  in/out  1  query-stream handshake.
- s_data  in  WIDTH  query sample.
- m_valid  out  1  bottom-row score valid. There is no backpressure.
- m_score  out  CWIDTH  D[NPE-1][j].
- m_pos  out  QW  column index j.
- best_score  out  CWIDTH  running minimum of m_score.
- best_pos  out  QW  index of best_score.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at job end.

## Operation
- FSM IDLE → LOAD → RUN → DRAIN → DONE → IDLE.
  - IDLE: start latches mode and qlen, clears the counters, and loads INF into every PE column register and into best_score.
  - LOAD: ref_ready=1. Each handshake shifts ref_data in; the first accepted sample ends in PE0. After NPE transfers → RUN.
  - RUN: s_ready=1. Each handshake injects s_data with a valid tag into PE0. After qlen transfers → DRAIN.
  - DRAIN: wait until the last tagged sample leaves PE NPE-1 and its m_valid has issued → DONE.
  - DONE: done=1 for one cycle → IDLE.
- PE i, on a tagged sample x_j:
  - cost = |x_j − r_i|, computed exactly in WIDTH+1 bits and held as WIDTH unsigned.
  - D[i][j] = sat(cost + min(N, W, NW)).
  - N = D[i−1][j] (upstream output this cycle); W = own D[i][j−1]; NW = upstream previous output, held locally.
  - The PE updates only on a tagged input. Bubbles leave all state untouched.
- Boundaries:
  - Row −1 in full mode: NW=0 for j=0, otherwise INF.
  - Row −1 in subsequence mode: N=0 and NW=0 for every j.
  - Column −1: W=INF for all rows.
- Saturation: any sum ≥ INF yields INF. min() on INF operands is ordinary unsigned compare.
- Best tracking:
  - Subsequence mode: best updates when m_score < best_score, strictly less, so ties keep the earliest j.
  - Full mode: best_score/best_pos take the final column (j=qlen−1) only.
- Handshakes: ref_ready and s_ready are low outside their own states. The block ignores start while busy.
- Reset: asserting rst_n low at any time, mid-job included, forces IDLE immediately. Every output goes to 0 except best_score, which goes to INF. The next job needs a fresh start and a fresh reference load.

## Timing
- Sample j accepted at edge t is processed by PE i at edge t+1+i. m_valid/m_score/m_pos are registered, valid in the cycle after edge t+NPE, so latency is NPE+1 edges.
- Throughput is one column per cycle with continuous s_valid. Gaps in s_valid propagate as bubbles: m_valid stays low for those cycles and scores are unchanged.
- best_score/best_pos update on the same edge that registers the corresponding m_valid.
- done rises one cycle after the last m_valid. busy falls together with done.

## Structure
- Package dtw_pkg holds:
  - state enum {IDLE, LOAD, RUN, DRAIN, DONE};
  - mode enum {MODE_FULL, MODE_SUBSEQ};
  - function inf(CWIDTH) returning all-ones;
  - saturating-add and min3 functions.
- Sub-module dtw_sdtw_pe: one cell holding the reference register, the W/NW registers, the tag pipeline and the x pass-through. The top instantiates NPE of them through a generate loop, plus the FSM and best tracker.

## Test plan
- NPE=4, ref {1,2,3,4}, full mode, query {1,2,3,4} → m_score column 3 = 0; best_score=0, best_pos=3; done 1 cycle after the 4th m_valid.
- Same reference, subsequence mode, query {9,1,2,3,4,9} → m_score at j=4 = 0; best_pos=4; the final column (j=5) ≠ 0 and best is not updated.
- Same as the previous case but with s_valid low every other cycle → identical m_score/m_pos sequence; m_valid count = 6.
- WIDTH=16, CWIDTH=16, NPE=2, ref {−32768, −32768}, query {32767, 32767}, full mode → final column m_score = 65535 (INF, saturated), no wrap.
- Pulse rst_n low mid-RUN → all outputs 0, best_score=INF, ready signals low. Start a new job with ref {0,0} and query {0} → score 0.
- Start pulsed during RUN is ignored. ref_valid held high during RUN is not accepted, and ref_ready stays 0.

Source files
------------

// File: rtl/dtw_pkg.sv
// Shared types and arithmetic helpers for the DTW systolic array.
// Cost values are handled in 64 bits here and cut to CWIDTH at the call site.
package dtw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef enum logic {
        MODE_FULL,
        MODE_SUBSEQ
    } mode_t;

    function automatic logic [63:0] inf(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Any sum reaching the all-ones value pins at INF, so costs never wrap.
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          w
    );
        logic [63:0] s;
        s = a + b;
        return (s >= inf(w)) ? inf(w) : s;
    endfunction

    function automatic logic [63:0] min3(
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [63:0] c
    );
        logic [63:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

endpackage

// File: rtl/dtw_sdtw_pe.sv
// One DTW cell: reference register, W/NW cost registers, tag and sample pass-through.
// Bubbles (tag low) leave every cost register untouched.
module dtw_sdtw_pe
    import dtw_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CWIDTH = 24,
    parameter bit FIRST  = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     ld,
    input  logic signed [WIDTH-1:0]  ref_in,
    output logic signed [WIDTH-1:0]  ref_out,
    input  logic                     tag_in,
    input  logic signed [WIDTH-1:0]  x_in,
    input  logic [CWIDTH-1:0]        d_in,
    output logic                     tag_out,
    output logic signed [WIDTH-1:0]  x_out,
    output logic [CWIDTH-1:0]        d_out,
    output logic [CWIDTH-1:0]        d_nxt
);

    localparam logic [CWIDTH-1:0] INF = CWIDTH'(inf(CWIDTH));
    // Column -1 is INF except the top-left corner seed of the first row.
    localparam logic [CWIDTH-1:0] NW0 = FIRST ? '0 : INF;

    logic [WIDTH:0]      diff;
    logic [WIDTH-1:0]    cost;
    logic [CWIDTH-1:0]   nw;
    logic [63:0]         m;

    always_comb begin
        diff  = {x_in[WIDTH-1], x_in} - {ref_out[WIDTH-1], ref_out};
        cost  = diff[WIDTH] ? WIDTH'(-diff) : diff[WIDTH-1:0];
        m     = min3(64'(d_in), 64'(d_out), 64'(nw));
        d_nxt = CWIDTH'(sat_add(64'(cost), m, CWIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_out <= '0;
            tag_out <= 1'b0;
            x_out   <= '0;
            d_out   <= '0;
            nw      <= '0;
        end else begin
            tag_out <= clr ? 1'b0 : tag_in;
            if (ld) begin
                ref_out <= ref_in;
            end
            if (clr) begin
                d_out <= INF;
                nw    <= NW0;
            end else if (tag_in) begin
                d_out <= d_nxt;
                nw    <= d_in;
                x_out <= x_in;
            end
        end
    end

endmodule

// File: rtl/dtw_sdtw_array.sv
// Linear systolic DTW array: NPE cells, job FSM and best-score tracker.
// Query samples enter PE0 one per cycle; bottom-row costs leave the last PE.
module dtw_sdtw_array
    import dtw_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CWIDTH = 24,
    parameter int NPE    = 8,
    parameter int QW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [QW-1:0]     qlen,
    input  logic              ref_valid,
    output logic              ref_ready,
    input  logic [WIDTH-1:0]  ref_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WIDTH-1:0]  s_data,
    output logic              m_valid,
    output logic [CWIDTH-1:0] m_score,
    output logic [QW-1:0]     m_pos,
    output logic [CWIDTH-1:0] best_score,
    output logic [QW-1:0]     best_pos,
    output logic              busy,
    output logic              done
);

    localparam logic [CWIDTH-1:0] INF = CWIDTH'(inf(CWIDTH));

    state_t                  state;
    mode_t                   mode_r;
    logic [QW-1:0]           qlen_r;
    logic [QW-1:0]           cnt;
    logic [QW-1:0]           ocnt;
    logic                    t0;
    logic signed [WIDTH-1:0] x0;
    logic                    clr;
    logic                    ld;
    logic                    last_in;
    logic [CWIDTH-1:0]       d_last;

    logic                    tag [NPE];
    logic signed [WIDTH-1:0] xv  [NPE];
    logic signed [WIDTH-1:0] rv  [NPE];
    logic [CWIDTH-1:0]       dv  [NPE];
    logic [CWIDTH-1:0]       dn  [NPE];

    assign ref_ready = (state == LOAD);
    assign s_ready   = (state == RUN);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign clr       = (state == IDLE) && start;
    assign ld        = ref_valid && ref_ready;
    assign last_in   = tag[NPE-2];
    assign d_last    = dn[NPE-1];
    assign m_valid   = tag[NPE-1];
    assign m_score   = dv[NPE-1];

    for (genvar i = 0; i < NPE; i++) begin : g_pe
        logic                    up_tag;
        logic signed [WIDTH-1:0] up_x;
        logic signed [WIDTH-1:0] up_r;
        logic [CWIDTH-1:0]       up_d;

        // Row -1: free start (0) in subsequence mode, unreachable otherwise.
        if (i == 0) begin : g_first
            assign up_tag = t0;
            assign up_x   = x0;
            assign up_d   = (mode_r == MODE_SUBSEQ) ? '0 : INF;
        end else begin : g_next
            assign up_tag = tag[i-1];
            assign up_x   = xv[i-1];
            assign up_d   = dv[i-1];
        end

        // References shift toward PE0 so the first sample lands there.
        if (i == NPE - 1) begin : g_rin
            assign up_r = ref_data;
        end else begin : g_rchain
            assign up_r = rv[i+1];
        end

        dtw_sdtw_pe #(
            .WIDTH (WIDTH),
            .CWIDTH(CWIDTH),
            .FIRST (i == 0)
        ) u_pe (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clr),
            .ld     (ld),
            .ref_in (up_r),
            .ref_out(rv[i]),
            .tag_in (up_tag),
            .x_in   (up_x),
            .d_in   (up_d),
            .tag_out(tag[i]),
            .x_out  (xv[i]),
            .d_out  (dv[i]),
            .d_nxt  (dn[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_r     <= MODE_FULL;
            qlen_r     <= '0;
            cnt        <= '0;
            ocnt       <= '0;
            t0         <= 1'b0;
            x0         <= '0;
            m_pos      <= '0;
            best_score <= INF;
            best_pos   <= '0;
        end else begin
            t0 <= s_valid && s_ready;
            if (s_valid && s_ready) begin
                x0 <= s_data;
            end

            if (last_in) begin
                m_pos <= ocnt;
                ocnt  <= ocnt + 1'b1;
                if (mode_r == MODE_SUBSEQ) begin
                    if (d_last < best_score) begin
                        best_score <= d_last;
                        best_pos   <= ocnt;
                    end
                end else if (ocnt == qlen_r - 1'b1) begin
                    best_score <= d_last;
                    best_pos   <= ocnt;
                end
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_r     <= mode_t'(mode);
                        qlen_r     <= (qlen == '0) ? QW'(1) : qlen;
                        cnt        <= '0;
                        ocnt       <= '0;
                        best_score <= INF;
                        best_pos   <= '0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (ref_valid) begin
                        if (cnt == QW'(NPE - 1)) begin
                            cnt   <= '0;
                            state <= RUN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (s_valid) begin
                        if (cnt == qlen_r - 1'b1) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (ocnt == qlen_r) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtw_sdtw_array.sv
// Bench for dtw_sdtw_array: a 4-PE/24-bit instance and a 2-PE/16-bit instance
// checked against a plain DTW matrix model plus hand-computed literals.
module tb_dtw_sdtw_array;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_start = 1'b0;
    logic        b_start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] qlen = '0;
    logic        ref_valid = 1'b0;
    logic [15:0] ref_data = '0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;

    logic        a_ref_ready, a_s_ready, a_m_valid, a_busy, a_done;
    logic [23:0] a_m_score, a_best_score;
    logic [15:0] a_m_pos, a_best_pos;
    logic        b_ref_ready, b_s_ready, b_m_valid, b_busy, b_done;
    logic [15:0] b_m_score, b_best_score;
    logic [15:0] b_m_pos, b_best_pos;

    always #5 clk = ~clk;

    dtw_sdtw_array #(.WIDTH(16), .CWIDTH(24), .NPE(4), .QW(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .mode(mode), .qlen(qlen),
        .ref_valid(ref_valid), .ref_ready(a_ref_ready), .ref_data(ref_data),
        .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
        .m_valid(a_m_valid), .m_score(a_m_score), .m_pos(a_m_pos),
        .best_score(a_best_score), .best_pos(a_best_pos),
        .busy(a_busy), .done(a_done)
    );

    dtw_sdtw_array #(.WIDTH(16), .CWIDTH(16), .NPE(2), .QW(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mode(mode), .qlen(qlen),
        .ref_valid(ref_valid), .ref_ready(b_ref_ready), .ref_data(ref_data),
        .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
        .m_valid(b_m_valid), .m_score(b_m_score), .m_pos(b_m_pos),
        .best_score(b_best_score), .best_pos(b_best_pos),
        .busy(b_busy), .done(b_done)
    );

    bit     sel = 1'b0;
    logic   v_rr, v_sr, v_mv, v_busy, v_done, o_mv;
    longint v_score, v_pos, v_best, v_bpos;

    assign v_rr    = sel ? b_ref_ready : a_ref_ready;
    assign v_sr    = sel ? b_s_ready : a_s_ready;
    assign v_mv    = sel ? b_m_valid : a_m_valid;
    assign o_mv    = sel ? a_m_valid : b_m_valid;
    assign v_busy  = sel ? b_busy : a_busy;
    assign v_done  = sel ? b_done : a_done;
    assign v_score = sel ? longint'(b_m_score) : longint'(a_m_score);
    assign v_pos   = sel ? longint'(b_m_pos) : longint'(a_m_pos);
    assign v_best  = sel ? longint'(b_best_score) : longint'(a_best_score);
    assign v_bpos  = sel ? longint'(b_best_pos) : longint'(a_best_pos);

    int     errors = 0;
    int     checks = 0;
    int     ref_q[$];
    int     q_q[$];
    longint exp_col[16];
    longint cap[16];
    longint prev[16];
    int     nq = 0;
    bit     sub_m = 1'b0;
    longint infv = 0;
    int     exp_j = 0;
    bit     active = 1'b0;
    bit     poke = 1'b0;
    bit     prev_mv = 1'b0;
    longint mbest = 0;
    longint mbest_pos = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Whole cost matrix straight from the recurrence; bottom row is kept.
    function automatic void model();
        longint d[8][16];
        longint n, w, nw, m, c, s;
        int     npe;
        npe = ref_q.size();
        for (int j = 0; j < nq; j++) begin
            for (int i = 0; i < npe; i++) begin
                c  = longint'(q_q[j]) - longint'(ref_q[i]);
                c  = (c < 0) ? -c : c;
                n  = (i == 0) ? (sub_m ? 0 : infv) : d[i-1][j];
                w  = (j == 0) ? infv : d[i][j-1];
                if (i == 0) nw = (sub_m || j == 0) ? 0 : infv;
                else        nw = (j == 0) ? infv : d[i-1][j-1];
                m  = (n < w) ? n : w;
                m  = (nw < m) ? nw : m;
                s  = c + m;
                d[i][j] = (s >= infv) ? infv : s;
            end
            exp_col[j] = d[npe-1][j];
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (v_mv) begin
                if (!active || exp_j >= nq) begin
                    chk("spurious_m_valid", 1, 0);
                end else begin
                    chk("m_pos", v_pos, exp_j);
                    chk("m_score", v_score, exp_col[exp_j]);
                    cap[exp_j] = v_score;
                    if (sub_m) begin
                        if (exp_col[exp_j] < mbest) begin
                            mbest     = exp_col[exp_j];
                            mbest_pos = exp_j;
                        end
                        chk("best_score", v_best, mbest);
                        chk("best_pos", v_bpos, mbest_pos);
                    end else if (exp_j == nq - 1) begin
                        chk("best_score_final", v_best, exp_col[exp_j]);
                        chk("best_pos_final", v_bpos, exp_j);
                    end
                    exp_j++;
                end
            end
            if (o_mv) chk("idle_instance_m_valid", 1, 0);
            if (v_done) chk("done_after_last_m_valid", (prev_mv && exp_j == nq) ? 1 : 0, 1);
            if (poke) chk("ref_ready_in_run", v_rr, 0);
            prev_mv = v_mv;
        end
    end

    task automatic wait_rdy(input bit sr);
        int t;
        t = 0;
        while (!(sr ? v_sr : v_rr) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk(sr ? "s_ready_timeout" : "ref_ready_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        if (sel) b_start = 1'b1;
        else     a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic load_ref();
        for (int k = 0; k < ref_q.size(); k++) begin
            ref_valid = 1'b1;
            ref_data  = 16'(ref_q[k]);
            wait_rdy(1'b0);
            @(posedge clk); #1;
        end
        ref_valid = 1'b0;
    endtask

    task automatic job(input bit s, input bit md, input bit gap, input bit pk);
        int t;
        sel       = s;
        sub_m     = md;
        nq        = q_q.size();
        infv      = s ? 64'd65535 : 64'd16777215;
        model();
        exp_j     = 0;
        mbest     = infv;
        mbest_pos = 0;
        for (int j = 0; j < 16; j++) cap[j] = -1;
        active    = 1'b1;
        mode      = md;
        qlen      = 16'(nq);
        pulse_start();
        chk("busy_after_start", v_busy, 1);
        load_ref();
        if (pk) begin
            poke      = 1'b1;
            ref_valid = 1'b1;
            ref_data  = 16'h7777;
        end
        for (int k = 0; k < nq; k++) begin
            if (gap) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = 16'(q_q[k]);
            if (pk && k == 1) begin
                if (s) b_start = 1'b1;
                else   a_start = 1'b1;
            end
            wait_rdy(1'b1);
            @(posedge clk); #1;
            a_start = 1'b0;
            b_start = 1'b0;
        end
        s_valid   = 1'b0;
        ref_valid = 1'b0;
        t = 0;
        while (!v_done && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("done_timeout", 0, 1);
        poke = 1'b0;
        @(posedge clk); #1;
        chk("busy_low_after_done", v_busy, 0);
        chk("done_one_cycle", v_done, 0);
        chk("m_valid_count", exp_j, nq);
        active = 1'b0;
    endtask

    task automatic rst_chk();
        chk("rst_m_valid", a_m_valid, 0);
        chk("rst_m_score", a_m_score, 0);
        chk("rst_m_pos", a_m_pos, 0);
        chk("rst_best_score", a_best_score, 24'hFFFFFF);
        chk("rst_best_pos", a_best_pos, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ref_ready", a_ref_ready, 0);
        chk("rst_s_ready", a_s_ready, 0);
        chk("rst_b_best_score", b_best_score, 16'hFFFF);
        chk("rst_b_m_score", b_m_score, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #12;
        rst_chk();
        @(negedge clk);
        rst_n = 1'b1;

        // Full DTW, exact match; start and ref_valid poked during RUN.
        ref_q = '{1, 2, 3, 4};
        q_q   = '{1, 2, 3, 4};
        job(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_full_model_j3", exp_col[3], 0);
        chk("lit_full_score_j3", cap[3], 0);
        chk("lit_full_best", a_best_score, 0);
        chk("lit_full_best_pos", a_best_pos, 3);

        // Subsequence DTW with a match embedded at j=1..4.
        q_q = '{9, 1, 2, 3, 4, 9};
        job(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lit_sub_model_j4", exp_col[4], 0);
        chk("lit_sub_model_j5", exp_col[5], 5);
        chk("lit_sub_score_j4", cap[4], 0);
        chk("lit_sub_score_j5", cap[5], 5);
        chk("lit_sub_best", a_best_score, 0);
        chk("lit_sub_best_pos", a_best_pos, 4);
        for (int j = 0; j < 6; j++) prev[j] = cap[j];

        // Same job with a bubble before every sample.
        job(1'b0, 1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 6; j++) chk("gap_same_score", cap[j], prev[j]);
        chk("gap_m_valid_count", exp_j, 6);

        // Saturation on the 16-bit instance.
        ref_q = '{-32768, -32768};
        q_q   = '{32767, 32767};
        job(1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_sat_model", exp_col[1], 65535);
        chk("lit_sat_score", cap[1], 65535);
        chk("lit_sat_best", b_best_score, 65535);

        // Reset in the middle of RUN.
        sel    = 1'b0;
        active = 1'b0;
        ref_q  = '{5, 6, 7, 8};
        mode   = 1'b0;
        qlen   = 16'd4;
        pulse_start();
        load_ref();
        s_valid = 1'b1;
        s_data  = 16'd3;
        wait_rdy(1'b1);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        rst_chk();
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh jobs after reset.
        ref_q = '{0, 0};
        q_q   = '{0};
        job(1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_zero_b", cap[0], 0);
        ref_q = '{0, 0, 0, 0};
        job(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_zero_a", cap[0], 0);
        chk("lit_zero_a_best", a_best_score, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
